conv_window_mac: RTL and testbench
==================================

# conv_window_mac

Convolution compute stage directly downstream of the sliding-window line buffer. Each cycle `win_valid` is high, it accepts one NFMAPS×KER_SIZE×KER_SIZE pixel window. It computes NOUT output-channel dot products against locally stored signed weights and adds a bias. It then requantizes each result (round, shift, optional ReLU, saturate) and emits NOUT pixels on a fixed 3-cycle pipeline, with no backpressure.

## Interface
- KER_SIZE, 3, kernel width/height; must match the upstream window generator.
- BITWIDTH, 8, pixel, weight and output pixel width.
- NFMAPS, 3, input feature maps per window.
- NOUT, 4, output channels computed in parallel.
- SHIFT, 0, requantization right-shift amount (0..ACCW-2).
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- w_start  in  1  pulse: clear weight store index and enter LOAD.
- w_valid  in  1  one weight/bias word present on w_data.
- w_data  in  BITWIDTH  signed weight or bias word.
- w_done  out  1  high while state is READY.
- win_valid  in  1  window present on win_data.
- win_data  in  NFMAPS*KER_SIZE*KER_SIZE*BITWIDTH  unsigned window pixels. Fmap f occupies the slice starting at f*KER_SIZE²*BITWIDTH; within it, tap t sits at t*BITWIDTH.
- out_valid  out  1  out_data valid this cycle.
- out_data  out  NOUT*BITWIDTH  channel o occupies [o*BITWIDTH +: BITWIDTH].
- win_drop  out  1  sticky: a window arrived while not READY.

## Operation
- Derived sizes: NTAP = NFMAPS*KER_SIZE². NWORD = NOUT*NTAP + NOUT. ACCW = 2*BITWIDTH + 2 + $clog2(NTAP).
- FSM states EMPTY, LOAD, READY.
- EMPTY → LOAD on w_start.
- LOAD: each w_valid stores w_data at index widx, then widx++.
  - Index ((o*NFMAPS+f)*KER_SIZE²+t) holds a weight.
  - Index NOUT*NTAP+o holds the bias of channel o.
  - The word stored at widx = NWORD-1 moves the FSM to READY.
- READY → LOAD on w_start, with widx cleared.
- w_start has priority over w_valid in the same cycle: widx becomes 0 and the word is discarded.
- w_valid outside LOAD is ignored.
- A window is accepted only in READY. A window with win_valid while not READY is discarded and sets win_drop. win_drop clears only on reset.
- Arithmetic:
  - Each pixel is zero-extended to BITWIDTH+1 and multiplied by the signed weight.
  - Products for channel o are summed over NFMAPS and all taps in ACCW bits, signed.
  - The bias is sign-extended, shifted left by SHIFT, and added.
- Requantize:
  - If SHIFT>0, add 1<<(SHIFT-1) (round half up), then arithmetic shift right by SHIFT.
  - Clamp per Configuration.
- Weights and biases are sampled at acceptance (stage 1). A reload started while windows are in flight does not corrupt them.

## Timing
- Reset values: w_done=0, out_valid=0, out_data=0, win_drop=0, state EMPTY, widx=0. Weight and bias storage is also reset to 0.
- Stage 1 (S1) registers the NOUT×NTAP products, the scaled biases and the valid bit.
- Stage 2 (S2) registers the adder-tree sum plus bias.
- Stage 3 (S3) registers the requantized, clamped output together with out_valid.
- Latency: win_valid sampled at edge N gives out_valid high during cycle N+3.
- Throughput is one window per cycle. Order is preserved.
- out_data holds its last value when out_valid=0.
- Reset mid-operation flushes all stages: no out_valid after rstn deasserts until a new window is accepted in READY.

## Configuration
- CONV_MAC_RELU_EN defined: the clamp range is [0, 2^BITWIDTH-1] and out_data is unsigned. This matches the unsigned pixel format of the next layer's line buffer.
- CONV_MAC_RELU_EN undefined: the clamp range is [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1] and out_data is two's complement.

## Structure
- Package conv_mac_pkg holds:
  - the state enum typedef (EMPTY, LOAD, READY);
  - functions computing ACCW and NTAP;
  - the requantize/clamp function, shared with testbench reference models.
- Sub-module conv_mac_requant is one channel's S3 logic (round, shift, clamp, register). It is instantiated NOUT times.

## Test plan
Unless stated otherwise: KER_SIZE=3, NFMAPS=3, NOUT=4, BITWIDTH=8, SHIFT=0, RELU enabled.
- Reset: rstn low, then release → all outputs 0, w_done=0. A window presented before loading → no out_valid, win_drop=1.
- Load all weights=1 and biases=0, then one window of all pixels=2 → w_done after the 112th word, out_valid exactly 3 cycles later, every channel =54.
- Saturation:
  - weights=127, pixels=255 → 255 on every channel;
  - weights=-128 → 0;
  - with CONV_MAC_RELU_EN undefined → -128 (0x80).
- Rounding with SHIFT=2: weights=1, bias=0, a single nonzero pixel=6, others 0 → (6+2)>>2=2. Pixel=5 → (5+2)>>2=1.
- 20 back-to-back windows with pixel value = window index; w_start issued at window 10 → 10 outputs of 27*i in order and no gaps, then win_drop=1 and no further outputs.
- rstn asserted with 2 windows in flight → out_valid stays 0 after release, state EMPTY.

Source files
------------

// File: rtl/conv_mac_pkg.sv
// Shared types and helpers for the convolution window MAC: FSM state encoding,
// derived-size functions, and the requantize/clamp rule used by each output channel.
package conv_mac_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    function automatic int calc_ntap(input int nfmaps, input int ker_size);
        return nfmaps * ker_size * ker_size;
    endfunction

    function automatic int calc_accw(input int bitwidth, input int ntap);
        return 2 * bitwidth + 2 + $clog2(ntap);
    endfunction

    // Round half up, arithmetic shift, then clamp to the output pixel range.
    // Works on a 64-bit signed value so any accumulator width up to 63 bits fits.
    function automatic logic signed [63:0] requant_clamp(input logic signed [63:0] acc,
                                                          input int shift,
                                                          input int bitwidth,
                                                          input bit relu);
        logic signed [63:0] v;
        logic signed [63:0] lo;
        logic signed [63:0] hi;
        v = acc;
        if (shift > 0) begin
            v = (v + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        if (relu) begin
            lo = 64'sd0;
            hi = (64'sd1 <<< bitwidth) - 64'sd1;
        end else begin
            lo = -(64'sd1 <<< (bitwidth - 1));
            hi = (64'sd1 <<< (bitwidth - 1)) - 64'sd1;
        end
        if (v < lo) begin
            v = lo;
        end else if (v > hi) begin
            v = hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/conv_mac_requant.sv
// One output channel's final stage: round, shift, clamp and register.
// The output register holds its value on cycles without a valid accumulator.
module conv_mac_requant
    import conv_mac_pkg::*;
#(
    parameter int ACCW     = 23,
    parameter int BITWIDTH = 8,
    parameter int SHIFT    = 0,
    parameter bit RELU_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_valid,
    input  logic [ACCW-1:0]     i_acc,
    output logic [BITWIDTH-1:0] o_data
);

    logic signed [63:0]  w_acc64;
    logic [BITWIDTH-1:0] w_q;
    logic [BITWIDTH-1:0] r_data;

    assign w_acc64 = {{(64-ACCW){i_acc[ACCW-1]}}, i_acc};
    assign w_q     = BITWIDTH'(requant_clamp(w_acc64, SHIFT, BITWIDTH, RELU_EN));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data <= '0;
        end else if (i_valid) begin
            r_data <= w_q;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/conv_window_mac.sv
// Convolution MAC stage: loads signed weights/biases, then turns each accepted
// window into NOUT requantized pixels over three register stages.
// Optional feature macro CONV_MAC_RELU_EN: clamp outputs to the unsigned range.
//
// Handshake: no backpressure. win_valid is a one-cycle qualifier; a window is
// taken only in READY, otherwise it is dropped and win_drop latches. out_valid
// marks the single cycle a result is on out_data.
module conv_window_mac
    import conv_mac_pkg::*;
#(
    parameter int KER_SIZE = 3,
    parameter int BITWIDTH = 8,
    parameter int NFMAPS   = 3,
    parameter int NOUT     = 4,
    parameter int SHIFT    = 0
) (
    input  logic                                       clk,
    input  logic                                       rstn,
    input  logic                                       w_start,
    input  logic                                       w_valid,
    input  logic [BITWIDTH-1:0]                        w_data,
    output logic                                       w_done,
    input  logic                                       win_valid,
    input  logic [NFMAPS*KER_SIZE*KER_SIZE*BITWIDTH-1:0] win_data,
    output logic                                       out_valid,
    output logic [NOUT*BITWIDTH-1:0]                   out_data,
    output logic                                       win_drop,
    output state_t                                     o_dbg_state
);

    localparam int NTAP  = calc_ntap(NFMAPS, KER_SIZE);
    localparam int NWORD = NOUT * NTAP + NOUT;
    localparam int ACCW  = calc_accw(BITWIDTH, NTAP);
    localparam int PW    = 2 * BITWIDTH + 1;
    localparam int IW    = $clog2(NWORD);
`ifdef CONV_MAC_RELU_EN
    localparam bit RELU_EN = 1'b1;
`else
    localparam bit RELU_EN = 1'b0;
`endif

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [IW-1:0]               r_widx;
    logic [IW-1:0]               w_widx_nxt;
    logic                        w_wr_en;
    logic                        w_accept;
    logic                        r_win_drop;
    logic signed [BITWIDTH-1:0]  r_wmem [NWORD];

    logic signed [PW-1:0]        r_prod [NOUT][NTAP];
    logic signed [ACCW-1:0]      r_bias [NOUT];
    logic signed [ACCW-1:0]      w_bias_sc [NOUT];
    logic signed [ACCW-1:0]      w_sum [NOUT];
    logic signed [ACCW-1:0]      r_acc [NOUT];
    logic                        r_v1;
    logic                        r_v2;
    logic                        r_v3;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= EMPTY;
            r_widx  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_widx  <= w_widx_nxt;
        end
    end

    // w_start wins over a same-cycle w_valid; the word is simply not stored.
    always_comb begin
        w_state_nxt = r_state;
        w_widx_nxt  = r_widx;
        w_wr_en     = 1'b0;
        if (w_start) begin
            w_state_nxt = LOAD;
            w_widx_nxt  = '0;
        end else if (r_state == LOAD && w_valid) begin
            w_wr_en = 1'b1;
            if (r_widx == IW'(NWORD - 1)) begin
                w_state_nxt = READY;
                w_widx_nxt  = '0;
            end else begin
                w_widx_nxt = r_widx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NWORD; i++) begin
                r_wmem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_wmem[r_widx] <= w_data;
        end
    end

    assign w_accept = win_valid && (r_state == READY);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_win_drop <= 1'b0;
        end else if (win_valid && (r_state != READY)) begin
            r_win_drop <= 1'b1;
        end
    end

    always_comb begin
        for (int o = 0; o < NOUT; o++) begin
            w_bias_sc[o] = {{(ACCW-BITWIDTH){r_wmem[IW'(NOUT*NTAP + o)][BITWIDTH-1]}},
                            r_wmem[IW'(NOUT*NTAP + o)]} <<< SHIFT;
        end
    end

    // Weights are captured into the products here, so a reload cannot touch
    // windows that are already past acceptance.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v1 <= 1'b0;
            for (int o = 0; o < NOUT; o++) begin
                r_bias[o] <= '0;
                for (int p = 0; p < NTAP; p++) begin
                    r_prod[o][p] <= '0;
                end
            end
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                for (int o = 0; o < NOUT; o++) begin
                    r_bias[o] <= w_bias_sc[o];
                    for (int p = 0; p < NTAP; p++) begin
                        r_prod[o][p] <= $signed({1'b0, win_data[p*BITWIDTH +: BITWIDTH]})
                                        * r_wmem[IW'(o*NTAP + p)];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NOUT; o++) begin
            w_sum[o] = r_bias[o];
            for (int p = 0; p < NTAP; p++) begin
                w_sum[o] = w_sum[o] + {{(ACCW-PW){r_prod[o][p][PW-1]}}, r_prod[o][p]};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            for (int o = 0; o < NOUT; o++) begin
                r_acc[o] <= '0;
            end
        end else begin
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (r_v1) begin
                for (int o = 0; o < NOUT; o++) begin
                    r_acc[o] <= w_sum[o];
                end
            end
        end
    end

    for (genvar g = 0; g < NOUT; g++) begin : g_rq
        conv_mac_requant #(
            .ACCW     (ACCW),
            .BITWIDTH (BITWIDTH),
            .SHIFT    (SHIFT),
            .RELU_EN  (RELU_EN)
        ) u_rq (
            .clk     (clk),
            .rstn    (rstn),
            .i_valid (r_v2),
            .i_acc   (r_acc[g]),
            .o_data  (out_data[g*BITWIDTH +: BITWIDTH])
        );
    end

    assign out_valid   = r_v3;
    assign w_done      = (r_state == READY);
    assign win_drop    = r_win_drop;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_conv_window_mac.sv
// Bench for conv_window_mac: two instances (SHIFT=0 and SHIFT=2) share stimulus and
// are scored against an arithmetic model of the convolution and requantization.
module tb_conv_window_mac;
    import conv_mac_pkg::*;

    localparam int KS    = 3;
    localparam int NF    = 3;
    localparam int NO    = 4;
    localparam int BW    = 8;
    localparam int NTAP  = NF * KS * KS;
    localparam int NWORD = NO * NTAP + NO;
    localparam int DW    = NTAP * BW;
    localparam int OW    = NO * BW;

    // clock / reset and shared inputs
    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          w_start = 1'b0;
    logic          w_valid = 1'b0;
    logic [BW-1:0] w_data = '0;
    logic          win_valid = 1'b0;
    logic [DW-1:0] win_data = '0;

    logic          w_done0, out_valid0, win_drop0;
    logic [OW-1:0] out_data0;
    state_t        st0;
    logic          w_done1, out_valid1, win_drop1;
    logic [OW-1:0] out_data1;
    state_t        st1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    conv_window_mac #(.KER_SIZE(KS), .BITWIDTH(BW), .NFMAPS(NF), .NOUT(NO), .SHIFT(0)) dut (
        .clk(clk), .rstn(rstn), .w_start(w_start), .w_valid(w_valid), .w_data(w_data),
        .w_done(w_done0), .win_valid(win_valid), .win_data(win_data),
        .out_valid(out_valid0), .out_data(out_data0), .win_drop(win_drop0), .o_dbg_state(st0)
    );

    conv_window_mac #(.KER_SIZE(KS), .BITWIDTH(BW), .NFMAPS(NF), .NOUT(NO), .SHIFT(2)) dut_s2 (
        .clk(clk), .rstn(rstn), .w_start(w_start), .w_valid(w_valid), .w_data(w_data),
        .w_done(w_done1), .win_valid(win_valid), .win_data(win_data),
        .out_valid(out_valid1), .out_data(out_data1), .win_drop(win_drop1), .o_dbg_state(st1)
    );

    // scoreboard
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [OW-1:0] exp_q0[$];
    logic [OW-1:0] exp_q1[$];
    int            exp_c0[$];
    int            exp_c1[$];

    // reference model state
    int m_w[NWORD];
    int ld[NWORD];
    int pix[NTAP];
    bit m_ready = 1'b0;
    bit m_loading = 1'b0;
    bit m_drop = 1'b0;
    int m_idx = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] model_out(input int sh);
        logic [OW-1:0] r;
        longint acc, lo, hi;
`ifdef CONV_MAC_RELU_EN
        lo = 0;
        hi = (longint'(1) << BW) - 1;
`else
        lo = -(longint'(1) << (BW - 1));
        hi = (longint'(1) << (BW - 1)) - 1;
`endif
        r = '0;
        for (int o = 0; o < NO; o++) begin
            acc = longint'(m_w[NO*NTAP + o]) * (longint'(1) << sh);
            for (int p = 0; p < NTAP; p++) begin
                acc = acc + longint'(pix[p]) * longint'(m_w[o*NTAP + p]);
            end
            if (sh > 0) acc = (acc + (longint'(1) << (sh - 1))) >>> sh;
            if (acc < lo) acc = lo;
            if (acc > hi) acc = hi;
            r[o*BW +: BW] = acc[BW-1:0];
        end
        return r;
    endfunction

    always @(negedge clk) begin : mon0
        bit ev;
        if (rstn) begin
            ev = (exp_c0.size() > 0) && (exp_c0[0] == cyc);
            chk("out_valid_s0", out_valid0, ev);
            if (ev) begin
                chk("out_data_s0", out_data0, exp_q0[0]);
                void'(exp_q0.pop_front());
                void'(exp_c0.pop_front());
            end
        end
    end

    always @(negedge clk) begin : mon1
        bit ev;
        if (rstn) begin
            ev = (exp_c1.size() > 0) && (exp_c1[0] == cyc);
            chk("out_valid_s2", out_valid1, ev);
            if (ev) begin
                chk("out_data_s2", out_data1, exp_q1[0]);
                void'(exp_q1.pop_front());
                void'(exp_c1.pop_front());
            end
        end
    end

    // driver tasks: each drives one cycle starting at a falling edge
    task automatic drive_cycle(input bit wv_win, input bit ws, input bit wv, input logic [BW-1:0] wd);
        for (int p = 0; p < NTAP; p++) win_data[p*BW +: BW] = 8'(pix[p]);
        win_valid = wv_win;
        w_start   = ws;
        w_valid   = wv;
        w_data    = wd;
        if (wv_win) begin
            if (m_ready) begin
                exp_q0.push_back(model_out(0));
                exp_c0.push_back(cyc + 3);
                exp_q1.push_back(model_out(2));
                exp_c1.push_back(cyc + 3);
            end else begin
                m_drop = 1'b1;
            end
        end
        if (ws) begin
            m_ready = 1'b0;
            m_loading = 1'b1;
            m_idx = 0;
        end else if (m_loading && wv) begin
            m_w[m_idx] = int'($signed(wd));
            m_idx++;
            if (m_idx == NWORD) begin
                m_loading = 1'b0;
                m_ready = 1'b1;
            end
        end
        @(negedge clk);
        win_valid = 1'b0;
        w_start   = 1'b0;
        w_valid   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic set_ld(input int wv, input int bv);
        for (int i = 0; i < NWORD; i++) ld[i] = (i < NO*NTAP) ? wv : bv;
    endtask

    task automatic set_pix(input int v);
        for (int p = 0; p < NTAP; p++) pix[p] = v;
    endtask

    task automatic load_all(input bit start_with_valid);
        drive_cycle(1'b0, 1'b1, start_with_valid, 8'hA5);
        for (int i = 0; i < NWORD; i++) begin
            if (i == NWORD - 1) begin
                chk("w_done_early_s0", w_done0, 0);
                chk("w_done_early_s2", w_done1, 0);
            end
            drive_cycle(1'b0, 1'b0, 1'b1, 8'(ld[i]));
        end
        chk("w_done_s0", w_done0, m_ready);
        chk("w_done_s2", w_done1, m_ready);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        exp_q0.delete(); exp_c0.delete();
        exp_q1.delete(); exp_c1.delete();
        m_ready = 1'b0; m_loading = 1'b0; m_drop = 1'b0; m_idx = 0;
        for (int i = 0; i < NWORD; i++) m_w[i] = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && (exp_c0.size() > 0 || exp_c1.size() > 0); k++) @(negedge clk);
        chk("drain_s0", exp_c0.size(), 0);
        chk("drain_s2", exp_c1.size(), 0);
    endtask

    task automatic chk_drop();
        chk("win_drop_s0", win_drop0, m_drop);
        chk("win_drop_s2", win_drop1, m_drop);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_out_data", out_data0, 0);
        chk("rst_w_done", w_done0, 0);
        chk("rst_win_drop", win_drop0, 0);
        chk("rst_state", st0, EMPTY);
        chk("rst_state_s2", st1, EMPTY);
        chk("rst_out_data_s2", out_data1, 0);

        // window before any weights: dropped
        set_pix(7);
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        chk_drop();
        idle(5);

        // weights 1, bias 0, pixels 2 -> 54 per channel
        set_ld(1, 0);
        load_all(1'b0);
        set_pix(2);
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        drain();

        // saturation both ways; reload starts with a same-cycle w_valid that must be discarded
        set_ld(127, 0);
        load_all(1'b1);
        set_pix(255);
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        drain();
        set_ld(-128, 0);
        load_all(1'b1);
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        drain();

        // rounding: one nonzero tap
        set_ld(1, 0);
        load_all(1'b0);
        set_pix(0);
        pix[13] = 6;
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        pix[13] = 5;
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        drain();

        // random weights/biases and windows, with stray w_valid while READY
        for (int i = 0; i < NWORD; i++) ld[i] = int'($urandom_range(0, 255));
        load_all(1'b0);
        for (int n = 0; n < 40; n++) begin
            for (int p = 0; p < NTAP; p++) pix[p] = int'($urandom_range(0, 255));
            drive_cycle($urandom_range(0, 3) != 0, 1'b0, 1'($urandom_range(0, 1)),
                        8'($urandom_range(0, 255)));
        end
        drain();
        chk_drop();

        // back-to-back stream with a reload issued alongside window 9
        do_reset();
        chk_drop();
        set_ld(1, 0);
        load_all(1'b0);
        for (int i = 0; i < 20; i++) begin
            set_pix(i);
            drive_cycle(1'b1, i == 9, 1'b0, '0);
        end
        drain();
        chk_drop();
        chk("reload_state", st0, LOAD);

        // reset with two windows in flight
        for (int i = 0; i < NWORD; i++) ld[i] = int'($urandom_range(0, 255));
        load_all(1'b0);
        for (int p = 0; p < NTAP; p++) pix[p] = int'($urandom_range(0, 255));
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        drive_cycle(1'b1, 1'b0, 1'b0, '0);
        do_reset();
        idle(6);
        chk("flush_state", st0, EMPTY);
        chk("flush_state_s2", st1, EMPTY);
        chk("flush_out_valid", out_valid0, 0);
        chk("flush_w_done", w_done0, 0);
        chk_drop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
